// File: rtl/ob_cmd_deser_if.sv
// Byte-stream ingress and command egress bundle for the order-book deserialiser.
// The slave side is the deserialiser; the master side is its upstream source and book.
interface ob_cmd_deser_if #(
  parameter int unsigned CMD_W = 64,
  parameter int unsigned ERR_W = 16
);
  logic             in_vld;
  logic             in_sop;
  logic             in_eop;
  logic [7:0]       in_data;
  logic             in_rdy;
  logic             cmd_full_r;
  logic             cmd_vld_r;
  logic [CMD_W-1:0] cmd_r;
  logic [ERR_W-1:0] err_cnt_r;

  modport slave (
    input  in_vld, in_sop, in_eop, in_data, cmd_full_r,
    output in_rdy, cmd_vld_r, cmd_r, err_cnt_r
  );

  modport master (
    output in_vld, in_sop, in_eop, in_data, cmd_full_r,
    input  in_rdy, cmd_vld_r, cmd_r, err_cnt_r
  );
endinterface

// File: rtl/ob_cmd_deser.sv
// Order-book ingress: assembles an SOP/EOP-framed byte stream (MSB first) into one
// command word, pushes it to the book as a one-cycle strobe, honours the book's
// registered full flag, and counts dropped malformed frames (saturating).
module ob_cmd_deser #(
  parameter int unsigned CMD_W = 64,
  parameter int unsigned ERR_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  ob_cmd_deser_if.slave bus
);
  localparam int unsigned BYTES = (CMD_W + 7) / 8;
  localparam int unsigned SH_W  = BYTES * 8;
  localparam int unsigned CNT_W = $clog2(BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_PEND} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [SH_W-1:0]  r_shift, w_shift_nxt;
  logic [CMD_W-1:0] r_cmd;
  logic             r_cmd_vld;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_in_rdy;
  logic             w_acc;
  logic             w_complete;
  logic             w_err_inc;
  logic             w_issue;

  assign w_in_rdy = (r_state != S_PEND) && rst;
  assign w_acc    = bus.in_vld && w_in_rdy;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state, byte assembly and drop detection.
  // Bytes shift in from the bottom rather than being written at their final slot;
  // once all BYTES have arrived, byte 0 sits in the top lane exactly as required.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_shift_nxt    = r_shift;
    w_complete     = 1'b0;
    w_err_inc      = 1'b0;
    if (r_state == S_PEND) begin
      if (!bus.cmd_full_r) w_state_nxt = S_IDLE;
    end else if (w_acc) begin
      if (bus.in_sop) begin
        // A sop while collecting abandons the partial frame and restarts.
        if (r_state == S_COLLECT) w_err_inc = 1'b1;
        w_shift_nxt    = SH_W'(bus.in_data);
        w_byte_cnt_nxt = CNT_W'(1);
        if (!bus.in_eop) begin
          w_state_nxt = S_COLLECT;
        end else if (BYTES == 1) begin
          w_complete = 1'b1;
        end else begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            w_err_inc   = 1'b1;
            w_state_nxt = S_DRAIN;
          end
          S_COLLECT: begin
            w_shift_nxt    = (r_shift << 8) | SH_W'(bus.in_data);
            w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
            if (r_byte_cnt == CNT_W'(BYTES - 1)) begin
              if (bus.in_eop) begin
                w_complete = 1'b1;
              end else begin
                w_err_inc   = 1'b1;
                w_state_nxt = S_DRAIN;
              end
            end else if (bus.in_eop) begin
              w_err_inc   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          S_DRAIN: begin
            if (bus.in_eop) w_state_nxt = S_IDLE;
          end
          default: ;
        endcase
      end
    end
    if (w_complete) w_state_nxt = bus.cmd_full_r ? S_PEND : S_IDLE;
  end

  // Issue decision: a finished or pending word goes out only when the book has room.
  always_comb begin
    w_issue = (w_complete || (r_state == S_PEND)) && !bus.cmd_full_r;
  end

  // Datapath registers: byte counter, shift register, command output, error counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_cmd      <= '0;
      r_cmd_vld  <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_byte_cnt <= w_byte_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_cmd_vld  <= w_issue;
      if (w_issue) r_cmd <= w_shift_nxt[CMD_W-1:0];
      if (w_err_inc && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign bus.in_rdy    = w_in_rdy;
  assign bus.cmd_vld_r = r_cmd_vld;
  assign bus.cmd_r     = r_cmd;
  assign bus.err_cnt_r = r_err_cnt;
endmodule

// File: tb/tb_ob_cmd_deser.sv
// Directed bench for ob_cmd_deser (CMD_W=64, 8-byte frames).
module tb_ob_cmd_deser;
  localparam int unsigned CMD_W = 64;
  localparam int unsigned ERR_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_err  = 0;
  int   pushes = 0;
  int   p0;

  always #5 clk = ~clk;

  ob_cmd_deser_if #(.CMD_W(CMD_W), .ERR_W(ERR_W)) bus ();

  ob_cmd_deser #(.CMD_W(CMD_W), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Count command pushes seen by the book.
  always @(negedge clk) if (rst && bus.cmd_vld_r) pushes++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic sop, input logic eop, input logic [7:0] d);
    int i;
    @(negedge clk);
    bus.in_vld  = 1'b1;
    bus.in_sop  = sop;
    bus.in_eop  = eop;
    bus.in_data = d;
    i = 0;
    while (!bus.in_rdy && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!bus.in_rdy) check("rdy_timeout", 64'(bus.in_rdy), 64'd1);
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] w);
    logic [63:0] t;
    for (int i = 0; i < 8; i++) begin
      t = w >> (56 - 8 * i);
      send_byte(i == 0, i == 7, t[7:0]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.cmd_full_r = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    n_err++;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    bus.in_vld = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    bus.in_data = '0;  bus.cmd_full_r = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_rdy", 64'(bus.in_rdy), 64'd0);
    check("rst_vld", 64'(bus.cmd_vld_r), 64'd0);
    check("rst_cmd", bus.cmd_r, 64'd0);
    check("rst_err", 64'(bus.err_cnt_r), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check("rdy_after_rst", 64'(bus.in_rdy), 64'd1);

    // 1) basic frame, not full
    p0 = pushes;
    send_frame(64'h0102030405060708);
    check("t1_vld", 64'(bus.cmd_vld_r), 64'd1);
    check("t1_cmd", bus.cmd_r, 64'h0102030405060708);
    @(posedge clk); #1;
    check("t1_vld_1cyc", 64'(bus.cmd_vld_r), 64'd0);
    @(negedge clk); #1;
    check("t1_pushes", 64'(pushes - p0), 64'd1);
    check("t1_err", 64'(bus.err_cnt_r), 64'd0);

    // 2) completion while book full -> held in PEND for 5 full cycles
    p0 = pushes;
    for (int i = 0; i < 7; i++) send_byte(i == 0, 1'b0, 8'(8'h11 + i));
    bus.cmd_full_r = 1'b1;
    send_byte(1'b0, 1'b1, 8'h18);
    check("t2_pend_vld", 64'(bus.cmd_vld_r), 64'd0);
    check("t2_pend_rdy", 64'(bus.in_rdy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_hold_rdy", 64'(bus.in_rdy), 64'd0);
      check("t2_hold_vld", 64'(bus.cmd_vld_r), 64'd0);
      check("t2_hold_cmd", bus.cmd_r, 64'h0102030405060708);
    end
    bus.cmd_full_r = 1'b0;
    @(posedge clk); #1;
    check("t2_vld", 64'(bus.cmd_vld_r), 64'd1);
    check("t2_cmd", bus.cmd_r, 64'h1112131415161718);
    check("t2_rdy", 64'(bus.in_rdy), 64'd1);
    send_frame(64'h2122232425262728);
    check("t2_next_vld", 64'(bus.cmd_vld_r), 64'd1);
    check("t2_next_cmd", bus.cmd_r, 64'h2122232425262728);
    @(negedge clk); #1;
    check("t2_pushes", 64'(pushes - p0), 64'd2);

    // 3) sop inside a partial frame restarts assembly
    do_reset();
    p0 = pushes;
    send_byte(1'b1, 1'b0, 8'hB0);
    send_byte(1'b0, 1'b0, 8'hB1);
    send_byte(1'b0, 1'b0, 8'hB2);
    send_frame(64'hAAA1A2A3A4A5A6A7);
    check("t3_vld", 64'(bus.cmd_vld_r), 64'd1);
    check("t3_cmd", bus.cmd_r, 64'hAAA1A2A3A4A5A6A7);
    @(negedge clk); #1;
    check("t3_err", 64'(bus.err_cnt_r), 64'd1);
    check("t3_pushes", 64'(pushes - p0), 64'd1);

    // 4) early eop, then over-long frame drained, then good frame
    do_reset();
    p0 = pushes;
    for (int i = 0; i < 5; i++) send_byte(i == 0, i == 4, 8'(8'hC0 + i));
    check("t4_short_err", 64'(bus.err_cnt_r), 64'd1);
    for (int i = 0; i < 10; i++) send_byte(i == 0, i == 9, 8'(8'hD0 + i));
    check("t4_long_err", 64'(bus.err_cnt_r), 64'd2);
    check("t4_long_rdy", 64'(bus.in_rdy), 64'd1);
    send_frame(64'hE0E1E2E3E4E5E6E7);
    check("t4_vld", 64'(bus.cmd_vld_r), 64'd1);
    check("t4_cmd", bus.cmd_r, 64'hE0E1E2E3E4E5E6E7);
    @(negedge clk); #1;
    check("t4_err", 64'(bus.err_cnt_r), 64'd2);
    check("t4_pushes", 64'(pushes - p0), 64'd1);

    // 5) stray bytes count once; error counter saturates
    do_reset();
    p0 = pushes;
    repeat (3) send_byte(1'b0, 1'b0, 8'h55);
    send_frame(64'hF0F1F2F3F4F5F6F7);
    check("t5_cmd", bus.cmd_r, 64'hF0F1F2F3F4F5F6F7);
    check("t5_err", 64'(bus.err_cnt_r), 64'd1);
    for (int i = 0; i < 65533; i++) send_byte(1'b1, 1'b1, 8'h00);
    check("t5_err_fffe", 64'(bus.err_cnt_r), 64'hFFFE);
    repeat (2) send_byte(1'b1, 1'b1, 8'h00);
    check("t5_err_ffff", 64'(bus.err_cnt_r), 64'hFFFF);
    send_byte(1'b1, 1'b1, 8'h00);
    check("t5_err_sat", 64'(bus.err_cnt_r), 64'hFFFF);
    @(negedge clk); #1;
    check("t5_pushes", 64'(pushes - p0), 64'd1);

    // 6) reset during PEND and during COLLECT
    p0 = pushes;
    bus.cmd_full_r = 1'b1;
    send_frame(64'h1020304050607080);
    check("t6_pend_rdy", 64'(bus.in_rdy), 64'd0);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("t6_rst_vld", 64'(bus.cmd_vld_r), 64'd0);
    check("t6_rst_cmd", bus.cmd_r, 64'd0);
    check("t6_rst_err", 64'(bus.err_cnt_r), 64'd0);
    check("t6_rst_rdy", 64'(bus.in_rdy), 64'd0);
    bus.cmd_full_r = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("t6_pend_nopush", 64'(pushes - p0), 64'd0);
    for (int i = 0; i < 4; i++) send_byte(i == 0, 1'b0, 8'(8'h60 + i));
    @(negedge clk); #2;
    rst = 1'b0;
    #1 check("t6_col_rdy", 64'(bus.in_rdy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("t6_col_nopush", 64'(pushes - p0), 64'd0);
    send_frame(64'h9192939495969798);
    check("t6_vld", 64'(bus.cmd_vld_r), 64'd1);
    check("t6_cmd", bus.cmd_r, 64'h9192939495969798);
    @(negedge clk); #1;
    check("t6_err", 64'(bus.err_cnt_r), 64'd0);
    check("t6_pushes", 64'(pushes - p0), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
